// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and constants for the SPI byte engine
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_t;

  localparam logic [7:0] SPI_DUMMY_BYTE = 8'hFF;
  localparam logic [2:0] SPI_CS_IDLE    = 3'b111;

  localparam int FLASH = 0;
  localparam int SD    = 1;
  localparam int EXT   = 2;

endpackage

// File: rtl/activity_stretch.sv
// rtl/activity_stretch.sv - stretches chip-select activity so short accesses stay visible on the LED
module activity_stretch #(
  parameter int LED_HOLD_W = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic led
);

  localparam logic [LED_HOLD_W:0] HOLD_ONE = (LED_HOLD_W+1)'(1);

  // One extra bit so the MSB sets exactly 2^LED_HOLD_W cycles after release.
  logic [LED_HOLD_W:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '1;
    end else if (active) begin
      hold_cnt <= '0;
    end else if (!hold_cnt[LED_HOLD_W]) begin
      hold_cnt <= hold_cnt + HOLD_ONE;
    end
  end

  assign led = active | ~hold_cnt[LED_HOLD_W];

endmodule

// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - byte-wide mode 0 SPI master with chip-select register and activity LED
module spi_byte_engine #(
  parameter int HALF_PERIOD = 1,
  parameter int LED_HOLD_W  = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_wr,
  input  logic [2:0] cs_din,
  input  logic       data_wr,
  input  logic       data_rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       flash_cs_n,
  output logic       sd_cs_n,
  output logic       ext_cs_n,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       flash_miso,
  input  logic       sd_miso,
  input  logic       ext_miso,
  output logic       activity_led
);

  import spi_pkg::*;

  localparam logic [3:0] HALF_RELOAD = 4'(HALF_PERIOD - 1);

  spi_state_t state, next_state;
  logic [3:0] half_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [2:0] cs_reg;
  logic [2:0] cs_pend;
  logic       pend_valid;
  logic       phase_done;
  logic       finish;
  logic       miso_bit;
  logic       cs_active;

  assign phase_done = (half_cnt == 4'd0);
  assign finish     = (state == ST_HIGH) && phase_done && (bit_cnt == 3'd7);

  always_comb begin
    miso_bit = 1'b1;
    if (!cs_reg[FLASH]) begin
      miso_bit = flash_miso;
    end else if (!cs_reg[SD]) begin
      miso_bit = sd_miso;
    end else if (!cs_reg[EXT]) begin
      miso_bit = ext_miso;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (data_wr || data_rd) next_state = ST_LOW;
      ST_LOW:  if (phase_done) next_state = ST_HIGH;
      ST_HIGH: if (phase_done) next_state = (bit_cnt == 3'd7) ? ST_IDLE : ST_LOW;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    spi_clk  = (state == ST_HIGH);
    spi_mosi = (state == ST_IDLE) ? 1'b1 : tx_shift[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt   <= HALF_RELOAD;
      bit_cnt    <= 3'd0;
      tx_shift   <= SPI_DUMMY_BYTE;
      rx_shift   <= SPI_DUMMY_BYTE;
      dout       <= SPI_DUMMY_BYTE;
      cs_reg     <= SPI_CS_IDLE;
      cs_pend    <= SPI_CS_IDLE;
      pend_valid <= 1'b0;
    end else begin
      if (next_state != state) begin
        half_cnt <= HALF_RELOAD;
      end else if (!phase_done) begin
        half_cnt <= half_cnt - 4'd1;
      end

      if (state == ST_IDLE && (data_wr || data_rd)) begin
        tx_shift <= data_wr ? din : SPI_DUMMY_BYTE;
        bit_cnt  <= 3'd0;
      end else if (state == ST_LOW && phase_done) begin
        rx_shift <= {rx_shift[6:0], miso_bit};
      end else if (state == ST_HIGH && phase_done) begin
        tx_shift <= {tx_shift[6:0], 1'b1};
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (finish) begin
        dout <= rx_shift;
      end

      // Selects only move while SCK is parked: in idle, or on the final falling edge.
      if (state == ST_IDLE) begin
        if (cs_wr) cs_reg <= cs_din;
      end else if (finish) begin
        if (cs_wr) begin
          cs_reg <= cs_din;
        end else if (pend_valid) begin
          cs_reg <= cs_pend;
        end
        pend_valid <= 1'b0;
      end else if (cs_wr) begin
        cs_pend    <= cs_din;
        pend_valid <= 1'b1;
      end
    end
  end

  assign flash_cs_n = cs_reg[FLASH];
  assign sd_cs_n    = cs_reg[SD];
  assign ext_cs_n   = cs_reg[EXT];
  assign cs_active  = (cs_reg != SPI_CS_IDLE);

  activity_stretch #(
    .LED_HOLD_W(LED_HOLD_W)
  ) u_activity_stretch (
    .clk   (clk),
    .rst   (rst),
    .active(cs_active),
    .led   (activity_led)
  );

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb/tb_spi_byte_engine.sv - directed self-checking bench for spi_byte_engine
module tb_spi_byte_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_wr;
  logic [2:0] cs_din;
  logic       data_wr;
  logic       data_rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;
  logic       flash_cs_n;
  logic       sd_cs_n;
  logic       ext_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       flash_miso;
  logic       sd_miso;
  logic       ext_miso;
  logic       activity_led;

  int         checks = 0;
  int         failures = 0;
  int         rises = 0;
  int         base;
  int         busy_cycles;
  int         led_cycles;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] sd_byte = 8'hFF;
  int         sd_base = 0;
  logic [2:0] sd_idx;
  logic [7:0] last_dout;
  logic       last_flash;

  spi_byte_engine #(
    .HALF_PERIOD(1),
    .LED_HOLD_W (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cs_wr       (cs_wr),
    .cs_din      (cs_din),
    .data_wr     (data_wr),
    .data_rd     (data_rd),
    .din         (din),
    .dout        (dout),
    .busy        (busy),
    .flash_cs_n  (flash_cs_n),
    .sd_cs_n     (sd_cs_n),
    .ext_cs_n    (ext_cs_n),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .flash_miso  (flash_miso),
    .sd_miso     (sd_miso),
    .ext_miso    (ext_miso),
    .activity_led(activity_led)
  );

  always #5 clk = ~clk;

  // SD device model: presents sd_byte MSB first, one bit per SCK cycle since sd_base.
  assign sd_idx  = 3'(rises - sd_base);
  assign sd_miso = sd_byte[~sd_idx];

  always @(posedge spi_clk) begin
    rises = rises + 1;
    mosi_cap = {mosi_cap[6:0], spi_mosi};
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 64) begin
      last_dout  = dout;
      last_flash = flash_cs_n;
      tick(1);
      n++;
    end
    busy_cycles = n;
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic write_cs(input logic [2:0] v);
    cs_wr  = 1'b1;
    cs_din = v;
    tick(1);
    cs_wr  = 1'b0;
  endtask

  task automatic count_led();
    int n = 0;
    while (activity_led === 1'b1 && n < 64) begin
      tick(1);
      n++;
    end
    led_cycles = n;
  endtask

  initial begin
    rst = 1'b1; cs_wr = 1'b0; cs_din = 3'b111; data_wr = 1'b0; data_rd = 1'b0;
    din = 8'h00; flash_miso = 1'b0; ext_miso = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_cs", {29'd0, ext_cs_n, sd_cs_n, flash_cs_n}, 32'h7);
    chk("rst_sck", {31'd0, spi_clk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd1);
    chk("rst_dout", {24'd0, dout}, 32'hFF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_led", {31'd0, activity_led}, 32'd0);

    write_cs(3'b110);
    chk("cs_flash_low", {31'd0, flash_cs_n}, 32'd0);
    chk("led_on", {31'd0, activity_led}, 32'd1);

    base = rises;
    din = 8'hA5; data_wr = 1'b1;
    tick(1);
    data_wr = 1'b0;
    chk("a5_busy_start", {31'd0, busy}, 32'd1);
    chk("a5_first_bit", {31'd0, spi_mosi}, 32'd1);
    wait_idle("a5");
    chk("a5_busy_len", busy_cycles, 32'd16);
    chk("a5_rises", rises - base, 32'd8);
    chk("a5_mosi", {24'd0, mosi_cap}, 32'hA5);
    chk("a5_dout", {24'd0, dout}, 32'h00);
    chk("a5_mosi_idle", {31'd0, spi_mosi}, 32'd1);

    write_cs(3'b101);
    chk("cs_sd_low", {29'd0, ext_cs_n, sd_cs_n, flash_cs_n}, 32'h5);
    sd_byte = 8'h3C; sd_base = rises; base = rises;
    data_rd = 1'b1;
    tick(1);
    data_rd = 1'b0;
    wait_idle("rd");
    chk("rd_dout_before", {24'd0, last_dout}, 32'h00);
    chk("rd_dout", {24'd0, dout}, 32'h3C);
    chk("rd_mosi", {24'd0, mosi_cap}, 32'hFF);
    chk("rd_rises", rises - base, 32'd8);

    write_cs(3'b110);
    base = rises;
    din = 8'h5A; data_wr = 1'b1;
    tick(1);
    data_wr = 1'b0;
    tick(3);
    din = 8'hFF; data_wr = 1'b1;
    tick(1);
    data_wr = 1'b0;
    wait_idle("drop");
    tick(2);
    chk("drop_busy", {31'd0, busy}, 32'd0);
    chk("drop_rises", rises - base, 32'd8);
    chk("drop_mosi", {24'd0, mosi_cap}, 32'h5A);

    din = 8'h00; data_wr = 1'b1; data_rd = 1'b1;
    tick(1);
    data_wr = 1'b0; data_rd = 1'b0;
    wait_idle("both");
    chk("both_mosi", {24'd0, mosi_cap}, 32'h00);

    din = 8'hC3; data_wr = 1'b1;
    tick(1);
    data_wr = 1'b0;
    tick(4);
    write_cs(3'b111);
    chk("defer_hold1", {31'd0, flash_cs_n}, 32'd0);
    tick(2);
    write_cs(3'b011);
    chk("defer_hold2", {29'd0, ext_cs_n, sd_cs_n, flash_cs_n}, 32'h6);
    wait_idle("defer");
    chk("defer_last_busy", {31'd0, last_flash}, 32'd0);
    chk("defer_applied", {29'd0, ext_cs_n, sd_cs_n, flash_cs_n}, 32'h3);

    din = 8'h81; data_wr = 1'b1;
    tick(1);
    data_wr = 1'b0;
    tick(8);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    write_cs(3'b110);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_sck", {31'd0, spi_clk}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_dout", {24'd0, dout}, 32'hFF);
    chk("mid_rst_cs", {29'd0, ext_cs_n, sd_cs_n, flash_cs_n}, 32'h7);
    tick(20);
    chk("mid_rst_later_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_later_cs", {29'd0, ext_cs_n, sd_cs_n, flash_cs_n}, 32'h7);
    chk("mid_rst_led", {31'd0, activity_led}, 32'd0);

    write_cs(3'b110);
    chk("led_sel", {31'd0, activity_led}, 32'd1);
    write_cs(3'b111);
    count_led();
    chk("led_hold", led_cycles, 32'd16);

    write_cs(3'b110);
    write_cs(3'b111);
    tick(9);
    write_cs(3'b110);
    chk("led_reselect", {31'd0, activity_led}, 32'd1);
    write_cs(3'b111);
    count_led();
    chk("led_rehold", led_cycles, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
